// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback path.
//   REG_AW     register address width
//   REG_X0     address of the hardwired-zero register
//   wb_src_e   which producer owns the write port in a given cycle
package regfile_wb_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_X0 = 5'd0;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Synchronous FIFO holding long-latency results {wa, wd} until they win
// the register-file write port.
//   clk, rst          clock, synchronous active-high reset
//   push, push_wa/wd  enqueue (ignored when full)
//   pop               dequeue head (ignored when empty)
//   full, empty       occupancy flags
//   head_wa/wd        current head entry, valid when !empty
module regfile_wb_arbiter_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [AW-1:0]    push_wa,
  input  logic [WIDTH-1:0] push_wd,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [AW-1:0]    head_wa,
  output logic [WIDTH-1:0] head_wd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    mem_wa [DEPTH];
  logic [WIDTH-1:0] mem_wd [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_wa = mem_wa[rptr];
  assign head_wd = mem_wd[rptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_wa[wptr] <= push_wa;
      mem_wd[wptr] <= push_wd;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: sole driver of the register-file write port. Merges
// single-cycle ALU results with FIFO-buffered long-latency results, and
// keeps a busy scoreboard of pending long-latency destinations.
//   clk, rst                   clock, synchronous active-high reset
//   alu_req/wa/wd, alu_stall   ALU result in; stall = result not taken
//   lsu_valid/ready/wa/wd      long-latency result handshake
//   sb_set, sb_set_wa          mark a destination busy at issue
//   rs0/rs1, rs0_busy/rs1_busy source busy query (x0 never busy)
//   rf_we, rf_wa, rf_wd        registered register-file write port
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_req,
  input  logic [REG_AW-1:0] alu_wa,
  input  logic [WIDTH-1:0]  alu_wd,
  output logic              alu_stall,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_wa,
  input  logic [WIDTH-1:0]  lsu_wd,
  input  logic              sb_set,
  input  logic [REG_AW-1:0] sb_set_wa,
  input  logic [REG_AW-1:0] rs0,
  input  logic [REG_AW-1:0] rs1,
  output logic              rs0_busy,
  output logic              rs1_busy,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [WIDTH-1:0]  rf_wd
);

  localparam int AGE_W = $clog2(STARVE_MAX + 1);

  logic              fifo_full, fifo_empty;
  logic [REG_AW-1:0] head_wa;
  logic [WIDTH-1:0]  head_wd;
  logic              grant_alu, grant_fifo, grant;
  wb_src_e           src;
  logic [REG_AW-1:0] g_wa;
  logic [WIDTH-1:0]  g_wd;
  logic [AGE_W-1:0]  age;
  logic [31:0]       busy;

  // Not pop-aware: a full FIFO refuses a push even when it pops that cycle.
  assign lsu_ready = !fifo_full && !rst;

  regfile_wb_arbiter_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (REG_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (lsu_valid && lsu_ready),
    .push_wa (lsu_wa),
    .push_wd (lsu_wd),
    .pop     (grant_fifo),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head_wa (head_wa),
    .head_wd (head_wd)
  );

  // During the stall pulse the ALU request is ignored, so the FIFO wins.
  always_comb begin
    grant_alu  = alu_req && !alu_stall;
    grant_fifo = !grant_alu && !fifo_empty;
    grant      = grant_alu || grant_fifo;
    src        = grant_alu ? WB_SRC_ALU : WB_SRC_LSU;
    g_wa       = (src == WB_SRC_ALU) ? alu_wa : head_wa;
    g_wd       = (src == WB_SRC_ALU) ? alu_wd : head_wd;
  end

  // A grant to x0 is consumed but never drives the write port; wa/wd hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= grant && (g_wa != REG_X0);
      if (grant && (g_wa != REG_X0)) begin
        rf_wa <= g_wa;
        rf_wd <= g_wd;
      end
    end
  end

  // Age counts consecutive losses of a waiting FIFO head; the stall flop
  // is a single-cycle pulse that hands one slot to the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      age       <= '0;
      alu_stall <= 1'b0;
    end else if (alu_stall) begin
      age       <= '0;
      alu_stall <= 1'b0;
    end else if (fifo_empty || grant_fifo) begin
      age <= '0;
    end else if (grant_alu) begin
      if (age == AGE_W'(STARVE_MAX - 1)) begin
        age       <= '0;
        alu_stall <= 1'b1;
      end else begin
        age <= age + AGE_W'(1);
      end
    end
  end

  // Set is written last so it wins over a same-cycle clear of the same reg.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (grant_fifo) busy[head_wa] <= 1'b0;
      if (sb_set && (sb_set_wa != REG_X0)) busy[sb_set_wa] <= 1'b1;
    end
  end

  assign rs0_busy = busy[rs0] && (rs0 != REG_X0);
  assign rs1_busy = busy[rs1] && (rs1 != REG_X0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_req;
  logic [4:0]  alu_wa;
  logic [31:0] alu_wd;
  logic        alu_stall;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_wa;
  logic [31:0] lsu_wd;
  logic        sb_set;
  logic [4:0]  sb_set_wa;
  logic [4:0]  rs0, rs1;
  logic        rs0_busy, rs1_busy;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(
    .WIDTH      (32),
    .DEPTH      (4),
    .STARVE_MAX (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_req   (alu_req),
    .alu_wa    (alu_wa),
    .alu_wd    (alu_wd),
    .alu_stall (alu_stall),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_wa    (lsu_wa),
    .lsu_wd    (lsu_wd),
    .sb_set    (sb_set),
    .sb_set_wa (sb_set_wa),
    .rs0       (rs0),
    .rs1       (rs1),
    .rs0_busy  (rs0_busy),
    .rs1_busy  (rs1_busy),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; alu_req = 1'b0; alu_wa = '0; alu_wd = '0;
    lsu_valid = 1'b0; lsu_wa = '0; lsu_wd = '0;
    sb_set = 1'b0; sb_set_wa = '0; rs0 = 5'd3; rs1 = 5'd31;

    // 1: reset and idle
    tick(); tick();
    chk1("rst_lsu_ready", lsu_ready, 1'b0);
    chk1("rst_rf_we", rf_we, 1'b0);
    rst = 1'b0;
    settle();
    chk1("idle_lsu_ready", lsu_ready, 1'b1);
    tick();
    chk1("idle_rf_we", rf_we, 1'b0);
    chk5("idle_rf_wa", rf_wa, 5'd0);
    chk32("idle_rf_wd", rf_wd, 32'h0);
    chk1("idle_rs0_busy", rs0_busy, 1'b0);
    chk1("idle_rs1_busy", rs1_busy, 1'b0);
    chk1("idle_alu_stall", alu_stall, 1'b0);

    // 2: ALU write, then x0 write suppressed
    alu_req = 1'b1; alu_wa = 5'd5; alu_wd = 32'hDEADBEEF;
    tick();
    chk1("alu_rf_we", rf_we, 1'b1);
    chk5("alu_rf_wa", rf_wa, 5'd5);
    chk32("alu_rf_wd", rf_wd, 32'hDEADBEEF);
    alu_wa = 5'd0; alu_wd = 32'h55;
    tick();
    chk1("x0_rf_we", rf_we, 1'b0);
    chk5("x0_rf_wa_hold", rf_wa, 5'd5);
    chk32("x0_rf_wd_hold", rf_wd, 32'hDEADBEEF);
    alu_req = 1'b0;
    tick();
    chk1("alu_idle_rf_we", rf_we, 1'b0);

    // 3: scoreboard set, LSU push, clear at commit (push + 2)
    sb_set = 1'b1; sb_set_wa = 5'd7; rs0 = 5'd7;
    tick();
    sb_set = 1'b0;
    settle();
    chk1("sb7_busy_set", rs0_busy, 1'b1);
    lsu_valid = 1'b1; lsu_wa = 5'd7; lsu_wd = 32'h1234;
    tick();
    lsu_valid = 1'b0;
    settle();
    chk1("sb7_busy_after_push", rs0_busy, 1'b1);
    chk1("lsu_no_bypass_we", rf_we, 1'b0);
    tick();
    chk1("lsu_rf_we", rf_we, 1'b1);
    chk5("lsu_rf_wa", rf_wa, 5'd7);
    chk32("lsu_rf_wd", rf_wd, 32'h1234);
    chk1("sb7_busy_cleared", rs0_busy, 1'b0);
    tick();
    chk1("lsu_done_rf_we", rf_we, 1'b0);

    // 4: fill FIFO behind a held ALU request, fifth push waits
    alu_req = 1'b1; alu_wa = 5'd11; alu_wd = 32'hA0;
    for (int i = 0; i < 4; i++) begin
      lsu_valid = 1'b1; lsu_wa = 5'(12 + i); lsu_wd = 32'h100 + 32'(i);
      settle();
      chk1("fill_lsu_ready", lsu_ready, 1'b1);
      tick();
    end
    lsu_wa = 5'd16; lsu_wd = 32'h104;
    settle();
    chk1("full_lsu_ready", lsu_ready, 1'b0);
    chk1("full_alu_rf_we", rf_we, 1'b1);
    chk5("full_alu_rf_wa", rf_wa, 5'd11);
    tick();
    alu_req = 1'b0;
    settle();
    chk1("full_pop_no_push_ready", lsu_ready, 1'b0);
    tick();
    chk1("drain0_rf_we", rf_we, 1'b1);
    chk5("drain0_rf_wa", rf_wa, 5'd12);
    chk32("drain0_rf_wd", rf_wd, 32'h100);
    settle();
    chk1("refill_lsu_ready", lsu_ready, 1'b1);
    for (int i = 1; i < 5; i++) begin
      tick();
      lsu_valid = 1'b0;
      chk1("drain_rf_we", rf_we, 1'b1);
      chk5("drain_rf_wa", rf_wa, 5'(12 + i));
      chk32("drain_rf_wd", rf_wd, 32'h100 + 32'(i));
    end
    tick();
    chk1("drain_done_rf_we", rf_we, 1'b0);
    chk1("drain_alu_stall", alu_stall, 1'b0);

    // 5: starvation pulse
    alu_req = 1'b1; alu_wa = 5'd21; lsu_wa = 5'd20; lsu_wd = 32'h2000;
    for (int k = 0; k < 9; k++) begin
      alu_wd = 32'h2100 + 32'(k);
      lsu_valid = (k == 0);
      tick();
      chk1("starve_rf_we", rf_we, 1'b1);
      chk32("starve_rf_wd", rf_wd, 32'h2100 + 32'(k));
      chk1("starve_alu_stall", alu_stall, (k == 8));
    end
    lsu_valid = 1'b0; alu_wd = 32'h2109;
    tick();
    chk5("stall_fifo_rf_wa", rf_wa, 5'd20);
    chk32("stall_fifo_rf_wd", rf_wd, 32'h2000);
    chk1("stall_pulse_drop", alu_stall, 1'b0);
    tick();
    chk1("held_alu_rf_we", rf_we, 1'b1);
    chk5("held_alu_rf_wa", rf_wa, 5'd21);
    chk32("held_alu_rf_wd", rf_wd, 32'h2109);
    alu_req = 1'b0;
    tick();
    chk1("starve_done_rf_we", rf_we, 1'b0);

    // 6a: set and clear of the same register in one cycle, set wins
    sb_set = 1'b1; sb_set_wa = 5'd9; rs1 = 5'd9;
    tick();
    sb_set = 1'b0;
    settle();
    chk1("sb9_busy_set", rs1_busy, 1'b1);
    lsu_valid = 1'b1; lsu_wa = 5'd9; lsu_wd = 32'h99;
    tick();
    lsu_valid = 1'b0; sb_set = 1'b1; sb_set_wa = 5'd9;
    tick();
    sb_set = 1'b0;
    chk1("sb9_commit_rf_we", rf_we, 1'b1);
    chk5("sb9_commit_rf_wa", rf_wa, 5'd9);
    chk1("sb9_set_wins", rs1_busy, 1'b1);

    // 6b: reset while the FIFO is draining
    alu_req = 1'b1; alu_wa = 5'd0; alu_wd = '0;
    sb_set = 1'b1; sb_set_wa = 5'd4; rs0 = 5'd4;
    for (int i = 0; i < 3; i++) begin
      lsu_valid = 1'b1; lsu_wa = 5'(1 + i); lsu_wd = 32'h300 + 32'(i);
      tick();
      sb_set = 1'b0;
    end
    lsu_valid = 1'b0; alu_req = 1'b0;
    tick();
    chk1("middrain_rf_we", rf_we, 1'b1);
    chk5("middrain_rf_wa", rf_wa, 5'd1);
    chk32("middrain_rf_wd", rf_wd, 32'h300);
    chk1("middrain_rs0_busy", rs0_busy, 1'b1);
    rst = 1'b1;
    settle();
    chk1("midrst_lsu_ready", lsu_ready, 1'b0);
    tick();
    chk1("midrst_rf_we", rf_we, 1'b0);
    chk1("midrst_rs0_busy", rs0_busy, 1'b0);
    chk1("midrst_rs1_busy", rs1_busy, 1'b0);
    rst = 1'b0;
    tick();
    chk1("postrst_rf_we_a", rf_we, 1'b0);
    tick();
    chk1("postrst_rf_we_b", rf_we, 1'b0);
    chk1("postrst_lsu_ready", lsu_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
